// File: rtl/pixel_window_capture.sv
// pixel_window_capture: grabs one rectangular window of a raster frame into a buffer and replays it
// row-major as a valid/ready stream. Define PIXEL_CAPTURE_DROP_STATS_EN to add the frames_dropped port.
module pixel_window_capture #(
    parameter int PIXEL_W = 9,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int WIN_X0  = 4,
    parameter int WIN_Y0  = 4,
    parameter int WIN_W   = 28,
    parameter int WIN_H   = 28
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               capture_enable,
    input  logic [X_W-1:0]     screen_x,
    input  logic [Y_W-1:0]     screen_y,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_in_valid,
    output logic [PIXEL_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
`ifdef PIXEL_CAPTURE_DROP_STATS_EN
    ,
    output logic [7:0]         frames_dropped
`endif
);
    localparam int N  = WIN_W * WIN_H;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [X_W-1:0] X_LO  = X_W'(WIN_X0);
    localparam logic [X_W-1:0] X_HI  = X_W'(WIN_X0 + WIN_W);
    localparam logic [X_W-1:0] X_END = X_W'(WIN_X0 + WIN_W - 1);
    localparam logic [Y_W-1:0] Y_LO  = Y_W'(WIN_Y0);
    localparam logic [Y_W-1:0] Y_HI  = Y_W'(WIN_Y0 + WIN_H);
    localparam logic [Y_W-1:0] Y_END = Y_W'(WIN_Y0 + WIN_H - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

    state_t             state, state_next;
    logic               sof, in_win, wr_en, wr_last, pop, issue;
    logic [X_W-1:0]     dx;
    logic [Y_W-1:0]     dy;
    logic [AW-1:0]      wr_addr;
    logic [1:0]         occ;
    logic [PIXEL_W-1:0] mem [N];
    logic [CW-1:0]      rd_ptr;
    logic [PIXEL_W-1:0] rd_data, sk_data;
    logic               rd_vld, rd_last, sk_vld, sk_last;

    // Raster decode plus read credit: at most two beats (output register + skid) may be owed downstream.
    always_comb begin
        sof     = pixel_in_valid && screen_x == '0 && screen_y == '0;
        in_win  = pixel_in_valid && screen_x >= X_LO && screen_x < X_HI && screen_y >= Y_LO && screen_y < Y_HI;
        dx      = screen_x - X_LO;
        dy      = screen_y - Y_LO;
        wr_addr = AW'(dy) * AW'(WIN_W) + AW'(dx);
        wr_en   = in_win && (state == CAPTURE || (state == ARMED && sof));
        wr_last = wr_en && screen_x == X_END && screen_y == Y_END;
        pop     = out_valid && out_ready;
        occ     = 2'(out_valid) + 2'(sk_vld) + 2'(rd_vld) - 2'(pop);
        issue   = state == READOUT && rd_ptr < CW'(N) && occ < 2'd2;
    end

    // Next-state logic; a SOF inside CAPTURE simply keeps capturing, overwriting the old contents.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = capture_enable ? ARMED : IDLE;
            ARMED:   state_next = sof ? CAPTURE : ARMED;
            CAPTURE: state_next = wr_last ? READOUT : CAPTURE;
            READOUT: state_next = (pop && out_last) ? (capture_enable ? ARMED : IDLE) : READOUT;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Window buffer: unreset storage with a registered read port.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= pixel_in;
        if (issue) rd_data <= mem[AW'(rd_ptr)];
    end

    // Read pipeline: in-flight read lands in the output register, or in the skid when the output stalls.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr    <= '0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            sk_vld    <= 1'b0;
            sk_last   <= 1'b0;
            sk_data   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            rd_vld <= issue;
            if (issue) begin
                rd_last <= rd_ptr == CW'(N - 1);
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_last) rd_ptr <= '0;
            if (!out_valid || pop) begin
                out_valid <= sk_vld || rd_vld;
                if (sk_vld)      {out_data, out_last} <= {sk_data, sk_last};
                else if (rd_vld) {out_data, out_last} <= {rd_data, rd_last};
                else             out_last <= 1'b0;
                sk_vld <= sk_vld && rd_vld;
                if (sk_vld && rd_vld) {sk_data, sk_last} <= {rd_data, rd_last};
            end else if (rd_vld) begin
                sk_vld  <= 1'b1;
                sk_data <= rd_data;
                sk_last <= rd_last;
            end
        end
    end

    assign busy = state == CAPTURE || state == READOUT;

`ifdef PIXEL_CAPTURE_DROP_STATS_EN
    // Saturating count of frames lost to readout or to a restarted capture.
    always_ff @(posedge clock) begin
        if (!reset) frames_dropped <= '0;
        else if (sof && busy && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pixel_window_capture.sv
// tb_pixel_window_capture: randomized raster frames against a window-extraction reference model.
module tb_pixel_window_capture;
    localparam int PW = 9, XW = 10, YW = 10, WX0 = 4, WY0 = 4, WW = 28, WH = 28;
    localparam int NPIX = WW * WH, RAST = 36, FRAME = RAST * RAST;

    logic          clock = 1'b0, reset = 1'b0, capture_enable = 1'b0, pixel_in_valid = 1'b0, out_ready = 1'b1;
    logic [XW-1:0] screen_x = '0;
    logic [YW-1:0] screen_y = '0;
    logic [PW-1:0] pixel_in = '0, out_data;
    logic          out_valid, out_last, busy;
`ifdef PIXEL_CAPTURE_DROP_STATS_EN
    logic [7:0]    frames_dropped;
`endif

    int vectors = 0, miscompares = 0;
    int cyc = 0, wr_cyc = 0, beats = 0, beats_exp = 0, valid_seen = 0, busy_seen = 0, drops_exp = 0, rdy_mode = 0;
    logic          stall_prev = 1'b0, prev_valid = 1'b0;
    logic [PW:0]   held = '0;
    logic [PW:0]   exp_q [$];
    logic [PW-1:0] frame [RAST][RAST];

    pixel_window_capture dut (
        .clock(clock), .reset(reset), .capture_enable(capture_enable),
        .screen_x(screen_x), .screen_y(screen_y), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
`ifdef PIXEL_CAPTURE_DROP_STATS_EN
        , .frames_dropped(frames_dropped)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_drops();
`ifdef PIXEL_CAPTURE_DROP_STATS_EN
        check("frames_dropped", 32'(frames_dropped), 32'(drops_exp));
`endif
    endtask

    // Output monitor: beat order, stall stability and first-beat latency.
    always @(negedge clock) begin
        if (!reset) begin
            stall_prev = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (pixel_in_valid && screen_x == XW'(WX0 + WW - 1) && screen_y == YW'(WY0 + WH - 1)) wr_cyc = cyc;
            if (out_valid && !prev_valid) check("first_valid_latency", 32'(cyc - wr_cyc), 32'd3);
            if (stall_prev) check("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", 32'(out_valid), 32'd0);
                else check("beat", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                beats++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_data};
            prev_valid = out_valid;
            valid_seen += int'(out_valid);
            busy_seen  += int'(busy);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        out_ready = rdy_mode == 0 ? 1'b1 : ((cyc % 2 == 0) && ($urandom_range(0, 3) != 0));
    endtask

    task automatic new_frame(input bit pattern);
        for (int y = 0; y < RAST; y++)
            for (int x = 0; x < RAST; x++)
                frame[y][x] = pattern ? PW'((y << 4) | x) : PW'($urandom);
    endtask

    // Reference: the window of the captured frame in row-major order, last flag on the final beat.
    task automatic push_window();
        for (int k = 0; k < NPIX; k++)
            exp_q.push_back({k == NPIX - 1, frame[WY0 + k / WW][WX0 + k % WW]});
    endtask

    task automatic drive_raster(input int npix, input logic en_after);
        for (int i = 0; i < npix; i++) begin
            screen_x       = XW'(i % RAST);
            screen_y       = YW'(i / RAST);
            pixel_in       = frame[i / RAST][i % RAST];
            pixel_in_valid = 1'b1;
            if (i == 1) capture_enable = en_after;
            tick();
        end
        pixel_in_valid = 1'b0;
    endtask

    task automatic arm();
        capture_enable = 1'b1;
        pixel_in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_done();
        int n = 0;
        pixel_in_valid = 1'b0;
        while ((busy || out_valid) && n < 5000) begin
            tick();
            n++;
        end
        check("drained_busy", 32'(busy), 32'd0);
        check("queue_left", 32'(exp_q.size()), 32'd0);
        check("beat_count", 32'(beats), 32'(beats_exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v0, b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        check_drops();

        // Pattern frame captured; next frame arrives during readout and is dropped.
        beats = 0; beats_exp = NPIX;
        new_frame(1'b1); push_window(); arm();
        drive_raster(FRAME, 1'b1);
        check("busy_in_readout", 32'(busy), 32'd1);
        new_frame(1'b0);
        drive_raster(FRAME, 1'b0);
        drops_exp++;
        wait_done(); check_drops();

        // Random frame with out_ready toggling and random stalls.
        rdy_mode = 1;
        beats = 0; beats_exp = NPIX;
        new_frame(1'b0); push_window(); arm();
        drive_raster(FRAME, 1'b0);
        wait_done(); check_drops();
        rdy_mode = 0;

        // SOF injected at (10,10) restarts capture; only the next frame is read out.
        beats = 0; beats_exp = NPIX;
        new_frame(1'b0); arm();
        drive_raster(10 * RAST + 10, 1'b1);
        new_frame(1'b0); push_window();
        drive_raster(FRAME, 1'b0);
        drops_exp++;
        wait_done(); check_drops();

        // SOF during readout is dropped; capture resumes at the following SOF.
        beats = 0; beats_exp = 2 * NPIX;
        new_frame(1'b0); push_window(); arm();
        drive_raster(FRAME, 1'b1);
        new_frame(1'b0);
        drive_raster(FRAME, 1'b1);
        drops_exp++;
        new_frame(1'b0); push_window();
        drive_raster(FRAME, 1'b0);
        wait_done(); check_drops();

        // Reset pulse at beat 100 of readout.
        beats = 0;
        new_frame(1'b0); push_window(); arm();
        drive_raster(32 * RAST, 1'b1);
        capture_enable = 1'b0;
        n = 0;
        while (beats < 100 && n < 3000) begin
            tick();
            n++;
        end
        check("reached_beat100", 32'(beats), 32'd100);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        drops_exp = 0;
        check_drops();
        tick();
        check("idle_after_rst", 32'(busy), 32'd0);

        // A one-cycle capture_enable pulse arms; ARMED survives enable dropping.
        capture_enable = 1'b1; tick();
        capture_enable = 1'b0; tick(); tick();
        beats = 0; beats_exp = NPIX;
        new_frame(1'b0); push_window();
        drive_raster(FRAME, 1'b0);
        wait_done(); check_drops();

        // From IDLE with capture_enable low nothing is captured across three frames.
        v0 = valid_seen; b0 = busy_seen;
        for (int f = 0; f < 3; f++) begin
            new_frame(1'b0);
            drive_raster(FRAME, 1'b0);
        end
        check("idle_no_valid", 32'(valid_seen - v0), 32'd0);
        check("idle_no_busy", 32'(busy_seen - b0), 32'd0);
        check_drops();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
